// File: rtl/legv8_multicycle_controller.sv
// LEGv8 multi-cycle control sequencer: fetch, decode, execute, memory, writeback.
// Define LEGV8_CBZ_EN to decode and execute CBZ; otherwise CBZ is treated as illegal.
module legv8_multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        branch,
  output logic        mem_read_dm,
  output logic        mem_write_dm,
  output logic        reg_write_rf,
  output logic        mux2,
  output logic        mux3,
  output logic [2:0]  alu_op,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [15:0] instret
);
  // state     | meaning
  // IDLE      | waiting for run
  // FETCH     | load IR, PC <= PC+4
  // DECODE    | classify instruction, trap illegal opcodes
  // EXECUTE   | ALU operation / branch resolution
  // MEMORY    | data-memory access, stalls until mem_ready
  // WRITEBACK | register-file write
  // HALT      | illegal opcode seen, exit only via reset
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3,
    MEMORY = 3'd4, WRITEBACK = 3'd5, HALT = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_ADD, CL_SUB, CL_AND, CL_ORR, CL_LDUR, CL_STUR, CL_CBZ, CL_B
  } class_t;

  state_t      st, st_nx;
  class_t      cls, cls_dec, cls_nx;
  logic        dec_ok, retire, pc_write_q;
  logic [10:0] ctl_q;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^instruction[20:0];

  always_comb begin
    cls_dec = CL_ADD;
    dec_ok  = 1'b1;
    case (instruction[31:21])
      11'b10001011000: cls_dec = CL_ADD;
      11'b11001011000: cls_dec = CL_SUB;
      11'b10001010000: cls_dec = CL_AND;
      11'b10101010000: cls_dec = CL_ORR;
      11'b11111000010: cls_dec = CL_LDUR;
      11'b11111000000: cls_dec = CL_STUR;
      default: begin
        dec_ok = 1'b0;
`ifdef LEGV8_CBZ_EN
        if (instruction[31:24] == 8'b10110100) begin
          cls_dec = CL_CBZ;
          dec_ok  = 1'b1;
        end
`endif
        if (instruction[31:26] == 6'b000101) begin
          cls_dec = CL_B;
          dec_ok  = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    st_nx  = st;
    retire = 1'b0;
    case (st)
      IDLE:      if (run) st_nx = FETCH;
      FETCH:     st_nx = DECODE;
      DECODE:    st_nx = dec_ok ? EXECUTE : HALT;
      EXECUTE: begin
        case (cls)
          CL_LDUR, CL_STUR: st_nx = MEMORY;
          CL_CBZ, CL_B:     retire = 1'b1;
          default:          st_nx = WRITEBACK;
        endcase
      end
      MEMORY: begin
        if (mem_ready) begin
          if (cls == CL_LDUR) st_nx = WRITEBACK;
          else                retire = 1'b1;
        end
      end
      WRITEBACK: retire = 1'b1;
      HALT:      st_nx = HALT;
      default:   st_nx = IDLE;
    endcase
    if (retire) st_nx = run ? FETCH : IDLE;
  end

  assign cls_nx = (st == DECODE) ? cls_dec : cls;

  // Control word for a given state/class: {ir, pc, br, mrd, mwr, rw, mux2, mux3, alu[2:0]}
  function automatic logic [10:0] ctl_of(input state_t s, input class_t c);
    logic       ir, pc, br, mrd, mwr, rw, m2, m3;
    logic [2:0] alu;
    {ir, pc, br, mrd, mwr, rw, m2, m3} = 8'b0;
    alu = 3'b000;
    case (s)
      FETCH: begin
        ir = 1'b1;
        pc = 1'b1;
      end
      EXECUTE: begin
        case (c)
          CL_ADD:  alu = 3'b010;
          CL_SUB:  alu = 3'b110;
          CL_AND:  alu = 3'b000;
          CL_ORR:  alu = 3'b001;
          CL_LDUR, CL_STUR: begin
            alu = 3'b010;
            m2  = 1'b1;
          end
`ifdef LEGV8_CBZ_EN
          CL_CBZ: begin
            alu = 3'b111;
            br  = 1'b1;
          end
`endif
          CL_B: begin
            br = 1'b1;
            pc = 1'b1;
          end
          default: alu = 3'b000;
        endcase
      end
      MEMORY: begin
        alu = 3'b010;
        m2  = 1'b1;
        mrd = (c == CL_LDUR);
        mwr = (c == CL_STUR);
      end
      WRITEBACK: begin
        rw = 1'b1;
        m3 = (c == CL_LDUR);
      end
      default: alu = 3'b000;
    endcase
    return {ir, pc, br, mrd, mwr, rw, m2, m3, alu};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      st      <= IDLE;
      cls     <= CL_ADD;
      ctl_q   <= 11'd0;
      illegal <= 1'b0;
      instret <= 16'd0;
    end else begin
      st    <= st_nx;
      cls   <= cls_nx;
      ctl_q <= ctl_of(st_nx, cls_nx);
      if (retire) instret <= instret + 16'd1;
      if (st == DECODE && !dec_ok) illegal <= 1'b1;
    end
  end

  assign {ir_write, pc_write_q, branch, mem_read_dm, mem_write_dm,
          reg_write_rf, mux2, mux3, alu_op} = ctl_q;
  // CBZ resolves the branch from the live zero flag during EXECUTE.
  assign pc_write = pc_write_q | ((st == EXECUTE) && (cls == CL_CBZ) && zero);
  assign state    = st;

endmodule

// File: tb/tb_legv8_multicycle_controller.sv
// Self-checking bench for legv8_multicycle_controller: instruction-level trace model
// expands each instruction into its expected per-cycle state and control word.
module tb_legv8_multicycle_controller;
  logic        clk = 1'b0;
  logic        reset, run, zero, mem_ready;
  logic [31:0] instruction;
  logic        ir_write, pc_write, branch, mem_read_dm, mem_write_dm;
  logic        reg_write_rf, mux2, mux3, illegal;
  logic [2:0]  alu_op, state;
  logic [15:0] instret;

  int   errors = 0, checks = 0, cyc = 0;
  int   m_instret = 0;
  logic m_illegal = 1'b0;
  int   n_cycles = 0, rd_cycles = 0;
  logic saw_pass_b = 1'b0;

  localparam logic [31:0] I_ADD  = 32'h8B020020, I_SUB = 32'hCB020020;
  localparam logic [31:0] I_AND  = 32'h8A020020, I_ORR = 32'hAA020020;
  localparam logic [31:0] I_LDUR = 32'hF8400000, I_STUR = 32'hF8000000;
  localparam logic [31:0] I_CBZ  = 32'hB4000040, I_B = 32'h14000010;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  legv8_multicycle_controller dut (
    .clk(clk), .reset(reset), .run(run), .instruction(instruction), .zero(zero),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
    .mem_read_dm(mem_read_dm), .mem_write_dm(mem_write_dm), .reg_write_rf(reg_write_rf),
    .mux2(mux2), .mux3(mux3), .alu_op(alu_op), .state(state), .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  function automatic logic [10:0] mk(input logic ir, pc, br, mrd, mwr, rw, m2, m3,
                                     input logic [2:0] alu);
    return {ir, pc, br, mrd, mwr, rw, m2, m3, alu};
  endfunction

  // 0 illegal, 1 ADD, 2 SUB, 3 AND, 4 ORR, 5 LDUR, 6 STUR, 7 CBZ, 8 B
  function automatic int kind_of(input logic [31:0] ins);
    if (ins[31:21] == 11'h458) return 1;
    if (ins[31:21] == 11'h658) return 2;
    if (ins[31:21] == 11'h450) return 3;
    if (ins[31:21] == 11'h550) return 4;
    if (ins[31:21] == 11'h7C2) return 5;
    if (ins[31:21] == 11'h7C0) return 6;
`ifdef LEGV8_CBZ_EN
    if (ins[31:24] == 8'hB4) return 7;
`endif
    if (ins[31:26] == 6'h05) return 8;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance to next negedge.
  task automatic step(input logic r, input logic rn, input logic [31:0] ins, input logic z,
                      input logic mr, input logic [2:0] es, input logic [10:0] ec);
    logic [10:0] ctl;
    reset = r; run = rn; instruction = ins; zero = z; mem_ready = mr;
    #1;
    ctl = {ir_write, pc_write, branch, mem_read_dm, mem_write_dm, reg_write_rf,
           mux2, mux3, alu_op};
    chk("state", {29'd0, state}, {29'd0, es});
    chk("controls", {21'd0, ctl}, {21'd0, ec});
    chk("illegal", {31'd0, illegal}, {31'd0, m_illegal});
    chk("instret", {16'd0, instret}, m_instret);
    if (mem_read_dm === 1'b1) rd_cycles++;
    if (alu_op === 3'b111) saw_pass_b = 1'b1;
    n_cycles++;
    cyc++;
    @(negedge clk);
    if (!r) begin
      m_instret = 0;
      m_illegal = 1'b0;
    end
  endtask

  // Expand one instruction into its expected cycle trace; run stays high except on the retiring cycle.
  task automatic do_instr(input logic [31:0] ins, input int stalls, input logic z,
                          input logic run_last);
    int k;
    logic [2:0] alu;
    k = kind_of(ins);
    step(1, 1, ins, z, 0, 3'd1, mk(1, 1, 0, 0, 0, 0, 0, 0, 3'b000));
    step(1, 1, ins, z, 0, 3'd2, 11'd0);
    if (k == 0) begin
      m_illegal = 1'b1;
      return;
    end
    case (k)
      1, 2, 3, 4: begin
        alu = (k == 1) ? 3'b010 : (k == 2) ? 3'b110 : (k == 3) ? 3'b000 : 3'b001;
        step(1, 1, ins, z, 0, 3'd3, mk(0, 0, 0, 0, 0, 0, 0, 0, alu));
        step(1, run_last, ins, z, 0, 3'd5, mk(0, 0, 0, 0, 0, 1, 0, 0, 3'b000));
      end
      5, 6: begin
        step(1, 1, ins, z, 0, 3'd3, mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b010));
        for (int i = 0; i <= stalls; i++)
          step(1, (k == 6 && i == stalls) ? run_last : 1'b1, ins, z, (i == stalls), 3'd4,
               mk(0, 0, 0, k == 5, k == 6, 0, 1, 0, 3'b010));
        if (k == 5)
          step(1, run_last, ins, z, 0, 3'd5, mk(0, 0, 0, 0, 0, 1, 0, 1, 3'b000));
      end
      7: step(1, run_last, ins, z, 0, 3'd3, mk(0, z, 1, 0, 0, 0, 0, 0, 3'b111));
      default: step(1, run_last, ins, z, 0, 3'd3, mk(0, 1, 1, 0, 0, 0, 0, 0, 3'b000));
    endcase
    m_instret = (m_instret + 1) % 65536;
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; instruction = 32'd0; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    step(0, 0, 0, 0, 0, 3'd0, 11'd0);
    step(0, 1, 0, 0, 0, 3'd0, 11'd0);
    step(1, 1, 0, 0, 0, 3'd0, 11'd0);

    n_cycles = 0;
    do_instr(I_ADD, 0, 0, 1);
    chk("add_latency", n_cycles, 4);
    chk("add_instret", {16'd0, instret}, 1);

    do_instr(I_SUB, 0, 0, 1);
    do_instr(I_AND, 0, 0, 1);
    do_instr(I_ORR, 0, 1, 1);

    n_cycles = 0; rd_cycles = 0;
    do_instr(I_LDUR, 3, 0, 1);
    chk("ldur_latency", n_cycles, 8);
    chk("ldur_read_cycles", rd_cycles, 4);
    chk("ldur_instret", {16'd0, instret}, 5);

    n_cycles = 0;
    do_instr(I_STUR, 0, 0, 1);
    chk("stur_latency", n_cycles, 4);
    do_instr(I_B, 0, 0, 1);

    // STUR aborted by reset during the second MEMORY cycle
    step(1, 1, I_STUR, 0, 0, 3'd1, mk(1, 1, 0, 0, 0, 0, 0, 0, 3'b000));
    step(1, 1, I_STUR, 0, 0, 3'd2, 11'd0);
    step(1, 1, I_STUR, 0, 0, 3'd3, mk(0, 0, 0, 0, 0, 0, 1, 0, 3'b010));
    step(1, 1, I_STUR, 0, 0, 3'd4, mk(0, 0, 0, 0, 1, 0, 1, 0, 3'b010));
    step(0, 1, I_STUR, 0, 0, 3'd4, mk(0, 0, 0, 0, 1, 0, 1, 0, 3'b010));
    chk("rst_stur_write", {31'd0, mem_write_dm}, 0);
    chk("rst_stur_instret", {16'd0, instret}, 0);
    step(1, 1, 0, 0, 0, 3'd0, 11'd0);

`ifdef LEGV8_CBZ_EN
    n_cycles = 0;
    do_instr(I_CBZ, 0, 1, 1);
    chk("cbz_taken_latency", n_cycles, 3);
    n_cycles = 0;
    do_instr(I_CBZ, 0, 0, 0);
    chk("cbz_not_taken_latency", n_cycles, 3);
    chk("cbz_instret", {16'd0, instret}, 2);
    step(1, 0, 0, 0, 0, 3'd0, 11'd0);
    step(1, 1, 0, 0, 0, 3'd0, 11'd0);
`else
    do_instr(I_CBZ, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 1, I_CBZ, 1, 0, 3'd6, 11'd0);
    chk("cbz_disabled_illegal", {31'd0, illegal}, 1);
    step(0, 1, I_CBZ, 1, 0, 3'd6, 11'd0);
    step(1, 1, 0, 0, 0, 3'd0, 11'd0);
`endif

    do_instr(I_BAD, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 1, I_BAD, 1, 1, 3'd6, 11'd0);
    chk("halt_illegal", {31'd0, illegal}, 1);
    step(0, 1, I_BAD, 0, 0, 3'd6, 11'd0);
    chk("halt_reset_state", {29'd0, state}, 0);
    chk("halt_reset_illegal", {31'd0, illegal}, 0);
    step(1, 0, 0, 0, 0, 3'd0, 11'd0);

`ifndef LEGV8_CBZ_EN
    chk("pass_b_never", {31'd0, saw_pass_b}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/legv8_multicycle_controller.md
# legv8_multicycle_controller

Multi-cycle control sequencer for the LEGv8 datapath (program counter, instruction memory, register file, ALU, data memory). It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath control lines `mem_write_dm`, `mem_read_dm`, `branch`, `reg_write_rf`, `mux2`, `mux3` and `alu_op`. It also drives the PC/IR write enables, stalls on the data-memory handshake, halts on illegal opcodes and counts retired instructions.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low reset.
- `run` in 1: 1 = execute instructions; sampled in IDLE and at the end of each instruction.
- `instruction` in 32: instruction-memory output; sampled only in DECODE.
- `zero` in 1: ALU zero flag; used only in CBZ EXECUTE.
- `mem_ready` in 1: data-memory access-complete strobe.
- `ir_write` out 1: instruction register load enable.
- `pc_write` out 1: PC update enable.
- `branch` out 1: 1 = PC source is the branch target, 0 = PC+4.
- `mem_read_dm` out 1: data-memory read.
- `mem_write_dm` out 1: data-memory write.
- `reg_write_rf` out 1: register-file write enable.
- `mux2` out 1: ALU B source; 1 = sign-extended immediate, 0 = register.
- `mux3` out 1: writeback source; 1 = data memory, 0 = ALU.
- `alu_op` out 3: 000 AND, 001 ORR, 010 ADD, 110 SUB, 111 pass-B.
- `state` out 3: current state encoding, for debug.
- `illegal` out 1: sticky illegal-opcode flag.
- `instret` out 16: retired-instruction count; wraps.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6.
- Reset (`reset`=0 at a clock edge), from any state:
  - State goes to IDLE.
  - `illegal`=0 and `instret`=0.
  - All control outputs are 0, including `alu_op`=000.
- IDLE: moves to FETCH when `run`=1.
- FETCH: `ir_write`=1, `pc_write`=1, `branch`=0. Next state is DECODE.
- DECODE: decodes `instruction` into a registered class and moves to EXECUTE. Matches:
  - [31:21]: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000.
  - [31:24]: CBZ 10110100.
  - [31:26]: B 000101.
  - No match: state goes to HALT and `illegal` is set.
- EXECUTE:
  - R-type: `alu_op` per opcode, `mux2`=0. Next state WRITEBACK.
  - LDUR/STUR: `alu_op`=010, `mux2`=1. Next state MEMORY.
  - CBZ: `alu_op`=111, `mux2`=0, `branch`=1, `pc_write`=`zero` (combinational). The instruction retires.
  - B: `branch`=1, `pc_write`=1. The instruction retires.
- MEMORY: `alu_op`=010 and `mux2`=1 are held throughout.
  - LDUR: `mem_read_dm`=1 until the cycle with `mem_ready`=1, then WRITEBACK.
  - STUR: `mem_write_dm`=1 until the cycle with `mem_ready`=1; the instruction retires.
  - `mem_ready` is ignored in all other states.
- WRITEBACK: `reg_write_rf`=1, `mux3`=1 for LDUR and 0 for R-type. The instruction retires.
- Retire:
  - `instret` increments by 1 (modulo 2^16).
  - Next state is FETCH if `run`=1, else IDLE.
- HALT: all control outputs are 0. The block stays in HALT regardless of `run`; only reset exits.
- All outputs are decoded from the registered state and class. The one exception is `pc_write` in CBZ EXECUTE, which follows `zero`.

## Timing
- Instruction latency in cycles (FETCH through the retiring state):
  - R-type: 4.
  - B/CBZ: 3.
  - STUR: 4 + N.
  - LDUR: 5 + N.
  - N = number of MEMORY cycles with `mem_ready`=0.
- `instret` updates on the clock edge that leaves the retiring state.
- `run` dropping mid-instruction does not abort; the instruction completes, then the block enters IDLE.
- `mem_ready` asserted in the first MEMORY cycle gives zero stall.
- Reset mid-MEMORY: the memory strobe drops in the cycle after the reset edge. No retire count is recorded.

## Configuration
- `LEGV8_CBZ_EN` defined: CBZ is decoded and executed as above.
- `LEGV8_CBZ_EN` undefined: CBZ decodes as illegal (HALT, `illegal`=1). `alu_op`=111 is never driven.

## Test plan
- ADD `instruction`=0x8B020020, `run`=1 after reset:
  - States go 1→2→3→5→1.
  - EXECUTE: `alu_op`=010, `mux2`=0.
  - WRITEBACK: `reg_write_rf`=1, `mux3`=0.
  - `instret`=1 after 4 cycles.
- LDUR 0xF8400000 with `mem_ready` low for 3 MEMORY cycles, then high:
  - `mem_read_dm`=1 for 4 cycles.
  - Then WRITEBACK with `mux3`=1.
  - 8 cycles total; `instret`+1.
- CBZ 0xB4000040:
  - `zero`=1: EXECUTE has `branch`=1, `pc_write`=1.
  - `zero`=0: `pc_write`=0.
  - Both cases: 3 cycles, `instret`+1.
- Illegal 0xFFFFFFFF:
  - HALT with `illegal`=1; all controls 0 for 20 cycles while `run`=1.
  - Then `reset`=0 for 1 cycle: state=0, `illegal`=0.
- STUR 0xF8000000 with `reset`=0 pulsed in the second MEMORY cycle (`mem_ready`=0):
  - Next cycle: state=0, `mem_write_dm`=0, `instret`=0.
- `LEGV8_CBZ_EN` undefined, CBZ 0xB4000040: HALT with `illegal`=1; `alu_op` never 111.
